// File: rtl/bundle_dispatcher_pkg.sv
// rtl/bundle_dispatcher_pkg.sv - shared widths, state encoding and beat slice helper
package bundle_dispatcher_pkg;

  localparam int BUNDLE_W = 256;
  localparam int INSTR_W  = 32;
  localparam int ISSUE_W  = 2;
  localparam int BEAT_W   = INSTR_W * ISSUE_W;
  localparam int BEATS    = BUNDLE_W / BEAT_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DISP = 2'd3
  } state_e;

  // Slot 0 of a beat sits in the low instruction word, slot 1 directly above it.
  function automatic logic [BEAT_W-1:0] beat_slice(input logic [BUNDLE_W-1:0] b,
                                                   input logic [1:0] beat);
    return b[int'(beat)*BEAT_W +: BEAT_W];
  endfunction

endpackage

// File: rtl/bundle_dispatcher.sv
// rtl/bundle_dispatcher.sv - pops one bundle from the fetch queue and issues it to decode beat by beat
module bundle_dispatcher
  import bundle_dispatcher_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                q_empty,
  output logic                q_rd,
  input  logic [BUNDLE_W-1:0] q_rdata,
  input  logic                flush,
  input  logic                out_ready,
  output logic                out_valid,
  output logic [BEAT_W-1:0]   out_instr,
  output logic [1:0]          out_beat,
  output logic [15:0]         bundles_done
);

  state_e                state_q;
  logic                  rd_q;
  logic                  valid_q;
  logic [1:0]            beat_q;
  logic [1:0]            beat_d;
  logic [BEAT_W-1:0]     instr_q;
  logic [BUNDLE_W-1:0]   buf_q;
  logic [15:0]           done_q;
  logic                  last_beat;

  assign beat_d    = beat_q + 2'd1;
  assign last_beat = (beat_q == 2'(BEATS - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rd_q    <= 1'b0;
      valid_q <= 1'b0;
      beat_q  <= 2'd0;
      instr_q <= '0;
      buf_q   <= '0;
      done_q  <= 16'd0;
    end else if (flush) begin
      // Any pop already issued is abandoned; buffer and count are left alone.
      state_q <= IDLE;
      rd_q    <= 1'b0;
      valid_q <= 1'b0;
      beat_q  <= 2'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!q_empty) begin
            state_q <= REQ;
            rd_q    <= 1'b1;
          end
        end
        REQ: begin
          rd_q    <= 1'b0;
          state_q <= WAIT;
        end
        WAIT: begin
          buf_q   <= q_rdata;
          instr_q <= beat_slice(q_rdata, 2'd0);
          beat_q  <= 2'd0;
          valid_q <= 1'b1;
          state_q <= DISP;
        end
        DISP: begin
          if (out_ready) begin
            if (last_beat) begin
              // Next pop is only requested off a fresh non-empty sample.
              done_q  <= done_q + 16'd1;
              beat_q  <= 2'd0;
              valid_q <= 1'b0;
              if (!q_empty) begin
                state_q <= REQ;
                rd_q    <= 1'b1;
              end else begin
                state_q <= IDLE;
              end
            end else begin
              beat_q  <= beat_d;
              instr_q <= beat_slice(buf_q, beat_d);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign q_rd         = rd_q;
  assign out_valid    = valid_q;
  assign out_instr    = instr_q;
  assign out_beat     = beat_q;
  assign bundles_done = done_q;

endmodule

// File: tb/tb_bundle_dispatcher.sv
// tb/tb_bundle_dispatcher.sv - directed table-driven bench for bundle_dispatcher
module tb_bundle_dispatcher;

  logic         clk = 1'b0;
  logic         rst;
  logic         q_empty = 1'b1;
  logic         q_rd;
  logic [255:0] q_rdata = '0;
  logic         flush;
  logic         out_ready;
  logic         out_valid;
  logic [63:0]  out_instr;
  logic [1:0]   out_beat;
  logic [15:0]  bundles_done;

  int n_vec = 0;
  int n_err = 0;
  logic [15:0] exp_done = 16'd0;

  logic [255:0] qm[$];

  typedef struct {
    logic        push;
    logic [31:0] base;
    logic        rdy;
    logic        e_rd;
    logic        e_valid;
    logic [1:0]  e_beat;
    logic [63:0] e_instr;
    logic [15:0] e_done;
  } row_t;

  row_t tbl[$];

  bundle_dispatcher dut (
    .clk          (clk),
    .rst          (rst),
    .q_empty      (q_empty),
    .q_rd         (q_rd),
    .q_rdata      (q_rdata),
    .flush        (flush),
    .out_ready    (out_ready),
    .out_valid    (out_valid),
    .out_instr    (out_instr),
    .out_beat     (out_beat),
    .bundles_done (bundles_done)
  );

  always #5 clk = ~clk;

  // Queue model: output register loads in the cycle q_rd is high, valid the next cycle.
  always @(negedge clk) begin
    if (q_rd && qm.size() > 0) q_rdata = qm.pop_front();
    q_empty = (qm.size() == 0);
  end

  function automatic logic [255:0] mk_bundle(input logic [31:0] base);
    logic [255:0] b;
    for (int k = 0; k < 8; k++) b[k*32 +: 32] = base + 32'(k);
    return b;
  endfunction

  function automatic logic [63:0] eb(input logic [31:0] base, input int b);
    return {base + 32'(2*b + 1), base + 32'(2*b)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic push, input logic [31:0] base, input logic rdy,
                     input logic e_rd, input logic e_valid, input logic [1:0] e_beat,
                     input logic [63:0] e_instr, input logic [15:0] e_done);
    row_t r;
    r.push = push; r.base = base; r.rdy = rdy; r.e_rd = e_rd; r.e_valid = e_valid;
    r.e_beat = e_beat; r.e_instr = e_instr; r.e_done = e_done;
    tbl.push_back(r);
  endtask

  initial begin
    bit ok;
    int nb, rd_cnt, last_cyc, cnt;

    rst = 1'b1; flush = 1'b0; out_ready = 1'b1;
    qm.push_back(mk_bundle(32'h0));

    // Single bundle, words 0..7, decode always ready.
    add(0, 32'h0, 1, 1, 0, 0, 64'h0, 16'd0);
    add(0, 32'h0, 1, 0, 0, 0, 64'h0, 16'd0);
    add(0, 32'h0, 1, 0, 1, 0, eb(32'h0, 0), 16'd0);
    add(0, 32'h0, 1, 0, 1, 1, eb(32'h0, 1), 16'd0);
    add(0, 32'h0, 1, 0, 1, 2, eb(32'h0, 2), 16'd0);
    add(0, 32'h0, 1, 0, 1, 3, eb(32'h0, 3), 16'd0);
    add(0, 32'h0, 1, 0, 0, 0, 64'h0, 16'd1);
    add(0, 32'h0, 1, 0, 0, 0, 64'h0, 16'd1);
    // Backpressure held for 5 cycles at beat 1.
    add(1, 32'h10, 1, 1, 0, 0, 64'h0, 16'd1);
    add(0, 32'h10, 1, 0, 0, 0, 64'h0, 16'd1);
    add(0, 32'h10, 1, 0, 1, 0, eb(32'h10, 0), 16'd1);
    add(0, 32'h10, 1, 0, 1, 1, eb(32'h10, 1), 16'd1);
    for (int i = 0; i < 5; i++) add(0, 32'h10, 0, 0, 1, 1, eb(32'h10, 1), 16'd1);
    add(0, 32'h10, 1, 0, 1, 2, eb(32'h10, 2), 16'd1);
    add(0, 32'h10, 1, 0, 1, 3, eb(32'h10, 3), 16'd1);
    add(0, 32'h10, 1, 0, 0, 0, 64'h0, 16'd2);

    for (int i = 0; i < 2; i++) begin
      tick();
      chk($sformatf("reset%0d q_rd", i), 64'(q_rd), 64'h0);
      chk($sformatf("reset%0d out_valid", i), 64'(out_valid), 64'h0);
      chk($sformatf("reset%0d bundles_done", i), 64'(bundles_done), 64'h0);
      chk($sformatf("reset%0d out_beat", i), 64'(out_beat), 64'h0);
    end
    rst = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].push) qm.push_back(mk_bundle(tbl[i].base));
      out_ready = tbl[i].rdy;
      tick();
      chk($sformatf("row%0d q_rd", i), 64'(q_rd), 64'(tbl[i].e_rd));
      chk($sformatf("row%0d out_valid", i), 64'(out_valid), 64'(tbl[i].e_valid));
      chk($sformatf("row%0d out_beat", i), 64'(out_beat), 64'(tbl[i].e_beat));
      chk($sformatf("row%0d bundles_done", i), 64'(bundles_done), 64'(tbl[i].e_done));
      if (tbl[i].e_valid) chk($sformatf("row%0d out_instr", i), out_instr, tbl[i].e_instr);
    end
    exp_done = 16'd2;

    // Three bundles back to back.
    out_ready = 1'b1;
    for (int n = 0; n < 3; n++) qm.push_back(mk_bundle(32'h100 * 32'(n + 1)));
    nb = 0; rd_cnt = 0; last_cyc = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      tick();
      if (q_rd) rd_cnt++;
      if (out_valid) begin
        if (nb < 12) begin
          chk($sformatf("b2b beat%0d out_instr", nb), out_instr, eb(32'h100 * 32'(nb/4 + 1), nb % 4));
          chk($sformatf("b2b beat%0d out_beat", nb), 64'(out_beat), 64'(nb % 4));
          if (nb % 4 == 0 && nb > 0) chk($sformatf("b2b gap%0d", nb/4), 64'(cyc - last_cyc), 64'd3);
        end
        last_cyc = cyc;
        nb++;
      end
    end
    exp_done = exp_done + 16'd3;
    chk("b2b beat count", 64'(nb), 64'd12);
    chk("b2b q_rd pulses", 64'(rd_cnt), 64'd3);
    chk("b2b bundles_done", 64'(bundles_done), 64'(exp_done));

    // Flush in DISP at beat 2; the next bundle must start clean.
    qm.push_back(mk_bundle(32'h400));
    qm.push_back(mk_bundle(32'h500));
    ok = 0;
    for (int c = 0; c < 20 && !ok; c++) begin
      tick();
      if (out_valid && out_beat == 2'd2) ok = 1;
    end
    chk("flush_disp reach beat2", 64'(ok), 64'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_disp out_valid", 64'(out_valid), 64'h0);
    chk("flush_disp out_beat", 64'(out_beat), 64'h0);
    chk("flush_disp bundles_done", 64'(bundles_done), 64'(exp_done));
    ok = 0;
    for (int c = 0; c < 20 && !ok; c++) begin
      tick();
      if (out_valid) ok = 1;
    end
    chk("flush_disp next valid", 64'(ok), 64'd1);
    chk("flush_disp next out_instr", out_instr, eb(32'h500, 0));
    chk("flush_disp next out_beat", 64'(out_beat), 64'h0);
    cnt = 0;
    while (out_valid && cnt < 10) begin tick(); cnt++; end
    exp_done = exp_done + 16'd1;
    chk("flush_disp drain bundles_done", 64'(bundles_done), 64'(exp_done));

    // Flush while the pop request is out: that bundle is lost.
    qm.push_back(mk_bundle(32'h600));
    qm.push_back(mk_bundle(32'h700));
    ok = 0;
    for (int c = 0; c < 10 && !ok; c++) begin
      tick();
      if (q_rd) ok = 1;
    end
    chk("flush_req see q_rd", 64'(ok), 64'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_req out_valid", 64'(out_valid), 64'h0);
    chk("flush_req q_rd", 64'(q_rd), 64'h0);
    ok = 0;
    for (int c = 0; c < 20 && !ok; c++) begin
      tick();
      if (out_valid) ok = 1;
    end
    chk("flush_req next valid", 64'(ok), 64'd1);
    chk("flush_req next out_instr", out_instr, eb(32'h700, 0));
    chk("flush_req next out_beat", 64'(out_beat), 64'h0);
    cnt = 0;
    while (out_valid && cnt < 10) begin tick(); cnt++; end
    exp_done = exp_done + 16'd1;
    chk("flush_req drain bundles_done", 64'(bundles_done), 64'(exp_done));
    chk("flush_req queue drained", 64'(qm.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
